// File: rtl/pre_cal.sv
// Pre-calculation stage of the 4x4 MIMO detector: registers A = H^T*H + snr*I and b = H^T*y.
// Build option PRECAL_SATURATE_EN clamps results to the signed DATA_W range; otherwise results wrap.
module pre_cal #(
  parameter int DATA_W = 32,
  parameter int N      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] H_matrix       [0:N-1][0:N-1],
  input  logic signed [DATA_W-1:0] signal_receive [0:N-1],
  input  logic signed [DATA_W-1:0] snr,
  output logic signed [DATA_W-1:0] matrix_A       [0:N-1][0:N-1],
  output logic signed [DATA_W-1:0] vector_b       [0:N-1]
);

  // Two DATA_W products, four-term sum plus snr: 2*DATA_W+3 bits cannot overflow.
  localparam int ACC_W = 2*DATA_W + 3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc_a;
  logic signed [ACC_W-1:0]  acc_b;
  logic signed [DATA_W-1:0] a_next [0:N-1][0:N-1];
  logic signed [DATA_W-1:0] b_next [0:N-1];

  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef PRECAL_SATURATE_EN
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  always_comb begin
    acc_a = '0;
    acc_b = '0;
    for (int i = 0; i < N; i++) begin
      b_next[i] = '0;
      for (int j = 0; j < N; j++) begin
        a_next[i][j] = '0;
      end
    end

    // Upper triangle only; the lower half is a copy so symmetry is exact.
    for (int i = 0; i < N; i++) begin
      for (int j = i; j < N; j++) begin
        acc_a = (i == j) ? ACC_W'(snr) : '0;
        for (int k = 0; k < N; k++) begin
          acc_a = acc_a + ACC_W'(H_matrix[k][i]) * ACC_W'(H_matrix[k][j]);
        end
        a_next[i][j] = reduce(acc_a);
      end
    end
    for (int i = 1; i < N; i++) begin
      for (int j = 0; j < i; j++) begin
        a_next[i][j] = a_next[j][i];
      end
    end

    for (int i = 0; i < N; i++) begin
      acc_b = '0;
      for (int k = 0; k < N; k++) begin
        acc_b = acc_b + ACC_W'(H_matrix[k][i]) * ACC_W'(signal_receive[k]);
      end
      b_next[i] = reduce(acc_b);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        vector_b[i] <= '0;
        for (int j = 0; j < N; j++) begin
          matrix_A[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        vector_b[i] <= b_next[i];
        for (int j = 0; j < N; j++) begin
          matrix_A[i][j] <= a_next[i][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_pre_cal.sv
// Self-checking bench for pre_cal: directed cases plus randomized vectors against a 128-bit reference.
// Honors PRECAL_SATURATE_EN when computing expected reduction.
module tb_pre_cal;
  localparam int DW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic reset;
  logic signed [DW-1:0] h     [0:N-1][0:N-1];
  logic signed [DW-1:0] y     [0:N-1];
  logic signed [DW-1:0] snr;
  logic signed [DW-1:0] mat_a [0:N-1][0:N-1];
  logic signed [DW-1:0] vec_b [0:N-1];
  logic signed [DW-1:0] exp_a [0:N-1][0:N-1];
  logic signed [DW-1:0] exp_b [0:N-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pre_cal #(.DATA_W(DW), .N(N)) dut (
    .clk(clk),
    .reset(reset),
    .H_matrix(h),
    .signal_receive(y),
    .snr(snr),
    .matrix_A(mat_a),
    .vector_b(vec_b)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic signed [DW-1:0] fit(input logic signed [127:0] v);
    logic signed [127:0] vmax;
    logic signed [127:0] vmin;
    vmax = 128'sd2147483647;
    vmin = -128'sd2147483648;
`ifdef PRECAL_SATURATE_EN
    if (v > vmax) return 32'h7FFF_FFFF;
    if (v < vmin) return 32'h8000_0000;
`endif
    return v[DW-1:0];
  endfunction

  // Reference: straight matrix-product definition, every entry from its own full sum.
  task automatic model(input logic rst);
    logic signed [127:0] s;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += 128'(h[k][i]) * 128'(y[k]);
      exp_b[i] = rst ? '0 : fit(s);
      for (int j = 0; j < N; j++) begin
        s = (i == j) ? 128'(snr) : 128'sd0;
        for (int k = 0; k < N; k++) s += 128'(h[k][i]) * 128'(h[k][j]);
        exp_a[i][j] = rst ? '0 : fit(s);
      end
    end
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s b[%0d]", tag, i), vec_b[i], exp_b[i]);
      for (int j = 0; j < N; j++)
        chk($sformatf("%s A[%0d][%0d]", tag, i, j), mat_a[i][j], exp_a[i][j]);
    end
  endtask

  task automatic cycle(input string tag);
    model(reset);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic fill(input logic signed [DW-1:0] hv, input logic signed [DW-1:0] yv,
                      input logic signed [DW-1:0] sv);
    for (int r = 0; r < N; r++) begin
      y[r] = yv;
      for (int c = 0; c < N; c++) h[r][c] = hv;
    end
    snr = sv;
  endtask

  task automatic rand_inputs(input bit wide);
    for (int r = 0; r < N; r++) begin
      y[r] = wide ? $signed($urandom) : $signed($urandom_range(0, 63)) - 32'sd32;
      for (int c = 0; c < N; c++)
        h[r][c] = wide ? $signed($urandom) : $signed($urandom_range(0, 63)) - 32'sd32;
    end
    snr = wide ? $signed($urandom) : $signed($urandom_range(0, 255)) - 32'sd128;
  endtask

  initial begin
    logic signed [DW-1:0] gen_h [0:N-1][0:N-1];
    logic signed [DW-1:0] gen_a [0:N-1][0:N-1];
    logic signed [DW-1:0] gen_b [0:N-1];
    logic signed [DW-1:0] ovf_a;

    // Reset held for two edges with nonzero inputs.
    reset = 1'b1;
    fill(32'sd7, 32'sd7, 32'sd7);
    cycle("rst1");
    cycle("rst2");
    reset = 1'b0;
    model(1'b1);
    check_out("rst_release");

    fill(32'sd1, 32'sd1, 32'sd1);
    cycle("ones");
    chk("ones diag", mat_a[2][2], 32'sd5);
    chk("ones offdiag", mat_a[1][3], 32'sd4);
    chk("ones b", vec_b[0], 32'sd4);

    fill(32'sd0, 32'sd0, 32'sd2);
    for (int r = 0; r < N; r++) h[r][r] = 32'sd1;
    y[0] = 32'sd3; y[1] = -32'sd2; y[2] = 32'sd7; y[3] = 32'sd0;
    cycle("ident");
    for (int i = 0; i < N; i++) begin
      chk($sformatf("ident b[%0d]", i), vec_b[i], y[i]);
      for (int j = 0; j < N; j++)
        chk($sformatf("ident A[%0d][%0d]", i, j), mat_a[i][j], (i == j) ? 32'sd3 : 32'sd0);
    end

    // Mixed-sign case; expected values recomputed by hand from the defining sums.
    gen_h = '{'{32'sd1, 32'sd2, 32'sd0, -32'sd1}, '{32'sd0, 32'sd1, 32'sd3, 32'sd2},
              '{-32'sd2, 32'sd0, 32'sd1, 32'sd1}, '{32'sd1, -32'sd1, 32'sd2, 32'sd0}};
    gen_a = '{'{32'sd6, 32'sd1, 32'sd0, -32'sd3}, '{32'sd1, 32'sd6, 32'sd1, 32'sd0},
              '{32'sd0, 32'sd1, 32'sd14, 32'sd7}, '{-32'sd3, 32'sd0, 32'sd7, 32'sd6}};
    gen_b = '{-32'sd1, 32'sd0, 32'sd17, 32'sd6};
    h = gen_h;
    y[0] = 32'sd1; y[1] = 32'sd2; y[2] = 32'sd3; y[3] = 32'sd4;
    snr = 32'sd0;
    cycle("signed");
    for (int i = 0; i < N; i++) begin
      chk($sformatf("signed const b[%0d]", i), vec_b[i], gen_b[i]);
      for (int j = 0; j < N; j++)
        chk($sformatf("signed const A[%0d][%0d]", i, j), mat_a[i][j], gen_a[i][j]);
    end

    // Every A entry is 2^34 at full precision.
`ifdef PRECAL_SATURATE_EN
    ovf_a = 32'h7FFF_FFFF;
`else
    ovf_a = 32'h0000_0000;
`endif
    fill(32'sh0001_0000, 32'sd0, 32'sd0);
    cycle("ovf");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("ovf const A[%0d][%0d]", i, j), mat_a[i][j], ovf_a);
    fill(-32'sh0001_0000, 32'sh0001_0000, 32'sd0);
    cycle("ovf_neg_b");

    // Back-to-back with reset pulsed on the third cycle.
    for (int c = 0; c < 5; c++) begin
      rand_inputs(1'b0);
      reset = (c == 2);
      cycle($sformatf("b2b%0d", c));
    end
    reset = 1'b0;

    for (int c = 0; c < 300; c++) begin
      rand_inputs(c[0]);
      reset = ($urandom_range(0, 15) == 0);
      cycle($sformatf("rnd%0d", c));
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
